usb_slave_fifo_ctrl: RTL and testbench
======================================

// Module: usb_slave_fifo_ctrl
// PURPOSE
//  Parametrised FX2 slave-FIFO master, clocked by the locked IFCLK, sitting between the usb_slave_fifo_interface_io pad layer and user logic.
//  Arbitrates one OUT endpoint (host->FPGA, RX) and one IN endpoint (FPGA->host, TX) on the shared FD bus.
//  Drives FIFOADR, SLOE, SLRD, SLWR and PKTEND; presents valid/ready streams on the user side.
//  Enforces bus turnaround, address settling and fair bursts.
// PARAMETERS
//  DATA_W      16     FD bus width, 8 or 16; upper FD bits are driven 0 when 8
//  RX_ADR      2'b00  FIFOADR for the OUT endpoint (EP2)
//  TX_ADR      2'b10  FIFOADR for the IN endpoint (EP6)
//  ADR_SETTLE  2      cycles from a FIFOADR change until flags are trusted, 1..7
//  BURST_MAX   64     maximum words per grant before re-arbitration, 1..2^12
//  PKT_WORDS   256    IN packet size in words; an internal counter wraps here
//  TIMEOUT     1024   idle cycles before an automatic short-packet PKTEND, 1..2^16
// PORTS
//  IFCLK        in   1       locked interface clock
//  rst_n        in   1       asynchronous, active-low reset
//  usb_flagB_in in   1       full flag of the addressed FIFO, active low
//  usb_flagC_in in   1       empty flag of the addressed FIFO, active low
//  usb_fd_in    in   DATA_W  FD bus read data
//  usb_fd_out   out  DATA_W  FD bus write data
//  usb_fd_oe_n  out  1       0 = FPGA drives FD
//  usb_fifo_adr out  2       FIFOADR[1:0]
//  usb_sloe     out  1       SLOE, active low
//  usb_slrd     out  1       SLRD, active low
//  usb_slwr     out  1       SLWR, active low
//  usb_pktend   out  1       PKTEND, active low
//  rx_data      out  DATA_W  OUT-endpoint word
//  rx_valid     out  1       rx_data valid
//  rx_ready     in   1       user accepts rx_data
//  tx_data      in   DATA_W  IN-endpoint word
//  tx_valid     in   1       tx_data valid
//  tx_ready     out  1       word accepted this cycle
//  tx_flush     in   1       one-cycle request to commit a short packet
// BEHAVIOUR
//  Reset: state IDLE; sloe/slrd/slwr/pktend=1; fd_oe_n=1; fifo_adr=RX_ADR; rx_valid=0; tx_ready=0; fd_out=0; all counters 0.
//  Reset asserted mid-transfer aborts at once: strobes are released and bus is tristated in the same edge (asynchronous).
//  States: IDLE, RX_ADR, RX_OE, RX_RD, TX_ADR, TX_WR, TX_END, TURN.
//  IDLE: requests are RX (pending while a sampled not-empty is held) and TX (tx_valid or pending flush). Both -> grant the side not served last (round robin). First grant after reset goes to RX.
//  RX_ADR/TX_ADR: drive adr; wait ADR_SETTLE cycles; flags are ignored throughout.
//  RX_OE: sloe=0 for one cycle before the first read; fd_oe_n stays 1 in every RX state.
//  RX_RD: slrd = rx_valid = usb_flagC_in & rx_ready; rx_data=usb_fd_in (0 latency); one word moves per cycle with slrd low.
//  RX_RD exits to TURN on empty (flagC=0), on burst count == BURST_MAX, or when rx_ready=0 while TX is pending. sloe returns to 1 in TURN.
//  TX_WR: fd_oe_n=0; slwr = tx_ready = usb_flagB_in & tx_valid; fd_out=tx_data.
//  TX_WR exits to TURN on full, at BURST_MAX, or when tx_valid=0; it goes to TX_END on tx_flush with 0 < word count < PKT_WORDS.
//  TX_END: pktend=0 for exactly one cycle with fd_oe_n=1 and slwr=1; the word count clears.
//  Word count increments per TX write; it wraps to 0 at PKT_WORDS because the FX2 auto-commits the packet there; a flush at count 0 is dropped.
//  tx_flush arriving outside TX_WR is latched as pending and served on the next TX grant, then TX_END.
//  TURN: one cycle, all strobes high, fd_oe_n=1; then IDLE. FPGA and FX2 never drive FD in the same cycle.
//  Full and empty on the same cycle are impossible per FIFO; only the flag of the addressed FIFO is used.
// CONFIGURATION
//  USB_TX_AUTO_PKTEND_EN defined: an idle counter counts cycles with 0 < word count < PKT_WORDS and no TX write.
//   At TIMEOUT the block raises an internal flush request, served as a normal tx_flush (TX_ADR->TX_END if not granted).
//   Any TX write clears the idle counter.
//  Not defined: counter logic absent; short packets commit only on tx_flush.
// TESTING
//  RX: FX2 model holds 10 words with flagC high, rx_ready=1 -> 10 slrd pulses, rx_data matches in order, TURN, IDLE.
//  TX backpressure: 300 words, flagB forced low after word 100 for 20 cycles -> exactly 300 slwr pulses, no write while full, wrap at 256.
//  Flush: 5 words then tx_flush -> single pktend pulse 1 cycle after the last slwr; tx_flush at count 0 -> no pktend.
//  Arbitration: RX and TX both pending with BURST_MAX=4 -> bursts alternate 4/4; TURN between each; fd_oe_n=0 never overlaps sloe=0.
//  Reset: rst_n low in the middle of TX_WR -> slwr, fd_oe_n and pktend high asynchronously; first post-reset grant is RX.
//  USB_TX_AUTO_PKTEND_EN with TIMEOUT=16: 3 words then idle -> pktend 16 cycles after the last write (+grant latency); undefined -> none.

Source files
------------

// File: rtl/usb_slave_fifo_ctrl.sv
// FX2 slave-FIFO master: arbitrates one OUT (RX) and one IN (TX) endpoint on the shared FD bus.
// Optional build macro USB_TX_AUTO_PKTEND_EN adds an idle-timeout short-packet commit.
module usb_slave_fifo_ctrl #(
   parameter int         DATA_W     = 16,
   parameter logic [1:0] RX_ADR     = 2'b00,
   parameter logic [1:0] TX_ADR     = 2'b10,
   parameter int         ADR_SETTLE = 2,
   parameter int         BURST_MAX  = 64,
   parameter int         PKT_WORDS  = 256,
   parameter int         TIMEOUT    = 1024
) (
   input  logic              IFCLK,
   input  logic              rst_n,
   input  logic              usb_flagB_in,
   input  logic              usb_flagC_in,
   input  logic [DATA_W-1:0] usb_fd_in,
   output logic [DATA_W-1:0] usb_fd_out,
   output logic              usb_fd_oe_n,
   output logic [1:0]        usb_fifo_adr,
   output logic              usb_sloe,
   output logic              usb_slrd,
   output logic              usb_slwr,
   output logic              usb_pktend,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic              tx_flush
);

   localparam int BW = $clog2(BURST_MAX + 1);
   localparam int WW = $clog2(PKT_WORDS + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RX_ADR, S_RX_OE, S_RX_RD, S_TX_ADR, S_TX_WR, S_TX_END, S_TURN
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    adr_q, adr_d;
   logic [2:0]    settle_q, settle_d;
   logic [BW-1:0] burst_q, burst_d;
   logic [WW-1:0] word_q, word_d;
   logic          last_rx_q, last_rx_d;
   logic          rx_pend_q, rx_pend_d;
   logic          flush_pend_q, flush_pend_d;

   logic rd_now, wr_now, rx_req, tx_req, flush_req, tx_exit, auto_flush;
   logic [WW-1:0] word_inc;

   assign rd_now    = (state_q == S_RX_RD) && usb_flagC_in && rx_ready;
   assign wr_now    = (state_q == S_TX_WR) && usb_flagB_in && tx_valid;
   // A held not-empty survives re-addressing to TX; otherwise only a flag of the RX FIFO counts.
   assign rx_req    = rx_pend_q || ((adr_q == RX_ADR) && usb_flagC_in);
   assign tx_req    = tx_valid || flush_pend_q;
   assign flush_req = flush_pend_q || tx_flush || auto_flush;
   assign word_inc  = (word_q == WW'(PKT_WORDS - 1)) ? '0 : word_q + 1'b1;
   assign tx_exit   = !usb_flagB_in || (burst_d == BW'(BURST_MAX)) || !tx_valid;
   assign rx_data   = usb_fd_in;
   assign usb_fifo_adr = adr_q;

`ifdef USB_TX_AUTO_PKTEND_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] idle_q;
   logic          idle_hit;

   assign idle_hit   = (idle_q == TW'(TIMEOUT - 1));
   assign auto_flush = !wr_now && (word_q != '0) && !flush_pend_q && idle_hit;

   always_ff @(posedge IFCLK or negedge rst_n) begin
      if (!rst_n) begin
         idle_q <= '0;
      end else if (wr_now || (word_q == '0) || flush_pend_q || idle_hit) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_q + 1'b1;
      end
   end
`else
   assign auto_flush = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      adr_d        = adr_q;
      settle_d     = settle_q;
      burst_d      = burst_q;
      word_d       = wr_now ? word_inc : word_q;
      last_rx_d    = last_rx_q;
      rx_pend_d    = rx_pend_q;
      flush_pend_d = flush_pend_q;
      usb_sloe     = 1'b1;
      usb_slrd     = 1'b1;
      usb_slwr     = 1'b1;
      usb_pktend   = 1'b1;
      usb_fd_oe_n  = 1'b1;
      usb_fd_out   = '0;
      rx_valid     = 1'b0;
      tx_ready     = 1'b0;

      case (state_q)
         S_IDLE: begin
            settle_d = '0;
            burst_d  = '0;
            if (rx_req && !(tx_req && last_rx_q)) begin
               state_d   = S_RX_ADR;
               adr_d     = RX_ADR;
               rx_pend_d = 1'b0;
            end else if (tx_req) begin
               state_d   = S_TX_ADR;
               adr_d     = TX_ADR;
               last_rx_d = 1'b0;
            end else if (adr_q != RX_ADR) begin
               // Nothing to do: park on the OUT endpoint so fresh RX data becomes visible.
               state_d = S_RX_ADR;
               adr_d   = RX_ADR;
            end
         end
         S_RX_ADR: begin
            if (settle_q == 3'(ADR_SETTLE - 1)) begin
               if (usb_flagC_in) begin
                  state_d   = S_RX_OE;
                  last_rx_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         S_RX_OE: begin
            usb_sloe = 1'b0;
            state_d  = S_RX_RD;
         end
         S_RX_RD: begin
            usb_sloe = 1'b0;
            usb_slrd = !rd_now;
            rx_valid = rd_now;
            burst_d  = burst_q + BW'(rd_now);
            if (!usb_flagC_in || (burst_d == BW'(BURST_MAX)) || (!rx_ready && tx_req)) begin
               state_d   = S_TURN;
               rx_pend_d = usb_flagC_in;
            end
         end
         S_TX_ADR: begin
            if (settle_q == 3'(ADR_SETTLE - 1)) begin
               state_d = S_TX_WR;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         S_TX_WR: begin
            usb_fd_oe_n = 1'b0;
            usb_fd_out  = tx_data;
            usb_slwr    = !wr_now;
            tx_ready    = wr_now;
            burst_d     = burst_q + BW'(wr_now);
            if (flush_req) begin
               // A flush landing on an empty (or just auto-committed) packet is dropped.
               flush_pend_d = 1'b0;
               if (word_d != '0) begin
                  state_d = S_TX_END;
               end else if (tx_exit) begin
                  state_d = S_TURN;
               end
            end else if (tx_exit) begin
               state_d = S_TURN;
            end
         end
         S_TX_END: begin
            usb_pktend = 1'b0;
            word_d     = '0;
            state_d    = S_IDLE;
         end
         S_TURN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if ((tx_flush || auto_flush) && (state_q != S_TX_WR) && (word_d != '0)) begin
         flush_pend_d = 1'b1;
      end
   end

   always_ff @(posedge IFCLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         adr_q        <= RX_ADR;
         settle_q     <= '0;
         burst_q      <= '0;
         word_q       <= '0;
         last_rx_q    <= 1'b0;
         rx_pend_q    <= 1'b0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         adr_q        <= adr_d;
         settle_q     <= settle_d;
         burst_q      <= burst_d;
         word_q       <= word_d;
         last_rx_q    <= last_rx_d;
         rx_pend_q    <= rx_pend_d;
         flush_pend_q <= flush_pend_d;
      end
   end

endmodule

// File: tb/tb_usb_slave_fifo_ctrl.sv
// Scoreboard bench for usb_slave_fifo_ctrl: FX2 FIFO model, queued expectations, strobe monitor.
module tb_usb_slave_fifo_ctrl;
   localparam int         DW     = 16;
   localparam logic [1:0] RXA    = 2'b00;
   localparam logic [1:0] TXA    = 2'b10;

   logic          IFCLK = 1'b0;
   logic          rst_n = 1'b0;
   logic          usb_flagB_in = 1'b1;
   logic          usb_flagC_in = 1'b0;
   logic [DW-1:0] usb_fd_in = '0;
   logic [DW-1:0] usb_fd_out;
   logic          usb_fd_oe_n;
   logic [1:0]    usb_fifo_adr;
   logic          usb_sloe, usb_slrd, usb_slwr, usb_pktend;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          rx_ready = 1'b1;
   logic [DW-1:0] tx_data = '0;
   logic          tx_valid = 1'b0;
   logic          tx_ready;
   logic          tx_flush = 1'b0;

   usb_slave_fifo_ctrl #(
      .DATA_W(DW), .RX_ADR(RXA), .TX_ADR(TXA), .ADR_SETTLE(2),
      .BURST_MAX(4), .PKT_WORDS(256), .TIMEOUT(16)
   ) dut (
      .IFCLK(IFCLK), .rst_n(rst_n), .usb_flagB_in(usb_flagB_in), .usb_flagC_in(usb_flagC_in),
      .usb_fd_in(usb_fd_in), .usb_fd_out(usb_fd_out), .usb_fd_oe_n(usb_fd_oe_n),
      .usb_fifo_adr(usb_fifo_adr), .usb_sloe(usb_sloe), .usb_slrd(usb_slrd), .usb_slwr(usb_slwr),
      .usb_pktend(usb_pktend), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_flush(tx_flush)
   );

   always #5 IFCLK = ~IFCLK;

   int checks = 0, failures = 0, cyc = 0;
   logic [DW-1:0] rx_model[$], rx_exp[$], tx_src[$], tx_exp[$];
   int  bursts[$];
   int  cur_burst = 0;
   int  rd_cnt = 0, wr_cnt = 0, pktend_cnt = 0, last_wr_cyc = 0, last_pe_cyc = 0;
   int  fx2_words = 0, full_at = -1, full_hold = 0;
   bit  rd_pend = 0, wr_pend = 0, flush_on_last = 0, flush_now = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: pops expectations whenever a strobe moves a word; protocol rules every cycle.
   always @(negedge IFCLK) begin
      if (rst_n) begin
         checks++;
         if ((!usb_fd_oe_n && !usb_sloe) || (!usb_slwr && !usb_flagB_in) ||
             (!usb_slrd && !usb_flagC_in) || (usb_slrd != !rx_valid) ||
             (usb_slwr != !tx_ready) || (!usb_slwr && usb_fd_oe_n) ||
             (!usb_pktend && (!usb_slwr || !usb_fd_oe_n))) begin
            failures++;
            $display("FAIL protocol cyc=%0d oe_n=%b sloe=%b slrd=%b slwr=%b pktend=%b flagB=%b flagC=%b",
                     cyc, usb_fd_oe_n, usb_sloe, usb_slrd, usb_slwr, usb_pktend, usb_flagB_in, usb_flagC_in);
         end
         if (!usb_slrd) begin
            rd_cnt++;
            if (rx_exp.size() == 0) chk("rx_unexpected_read", 1, 0);
            else chk("rx_data", rx_data, rx_exp.pop_front());
            if (cur_burst < 0) begin bursts.push_back(cur_burst); cur_burst = 0; end
            cur_burst++;
         end else if (!usb_slwr) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            if (tx_exp.size() == 0) chk("tx_unexpected_write", 1, 0);
            else chk("fd_out", usb_fd_out, tx_exp.pop_front());
            if (cur_burst > 0) begin bursts.push_back(cur_burst); cur_burst = 0; end
            cur_burst--;
         end else if (cur_burst != 0) begin
            bursts.push_back(cur_burst);
            cur_burst = 0;
         end
         if (!usb_pktend) begin
            pktend_cnt++;
            last_pe_cyc = cyc;
         end
      end else begin
         cur_burst = 0;
      end
      rd_pend = !usb_slrd;
      wr_pend = !usb_slwr;
   end

   // FX2 model and TX source, updated just after each rising edge.
   always begin
      @(posedge IFCLK);
      cyc++;
      #1;
      if (rd_pend && rx_model.size() > 0) void'(rx_model.pop_front());
      if (full_hold > 0) full_hold--;
      if (wr_pend) begin
         if (tx_src.size() > 0) void'(tx_src.pop_front());
         fx2_words++;
         if (fx2_words == full_at) full_hold = 20;
      end
      tx_flush = 1'b0;
      if (flush_now) begin tx_flush = 1'b1; flush_now = 0; end
      if (flush_on_last && tx_src.size() == 1) begin tx_flush = 1'b1; flush_on_last = 0; end
      tx_valid     = tx_src.size() > 0;
      tx_data      = (tx_src.size() > 0) ? tx_src[0] : '0;
      usb_flagC_in = (usb_fifo_adr == RXA) && (rx_model.size() > 0);
      usb_flagB_in = (usb_fifo_adr == TXA) ? (full_hold == 0) : 1'b1;
      usb_fd_in    = (rx_model.size() > 0) ? rx_model[0] : '0;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_b[$];
      logic [DW-1:0] w;
      repeat (3) @(negedge IFCLK);
      chk("rst_sloe", usb_sloe, 1);     chk("rst_slrd", usb_slrd, 1);
      chk("rst_slwr", usb_slwr, 1);     chk("rst_pktend", usb_pktend, 1);
      chk("rst_oe_n", usb_fd_oe_n, 1);  chk("rst_adr", usb_fifo_adr, RXA);
      chk("rst_rx_valid", rx_valid, 0); chk("rst_tx_ready", tx_ready, 0);
      chk("rst_fd_out", usb_fd_out, 0);
      @(posedge IFCLK); #2 rst_n = 1'b1;
      repeat (4) @(negedge IFCLK);

      // RX: 10 words from the OUT endpoint
      rd_cnt = 0; bursts.delete();
      for (int i = 0; i < 10; i++) begin
         w = DW'(16'hA000 + i); rx_model.push_back(w); rx_exp.push_back(w);
      end
      for (int i = 0; i < 300 && rx_exp.size() != 0; i++) @(negedge IFCLK);
      repeat (6) @(negedge IFCLK);
      chk("rx_drained", rx_exp.size(), 0);
      chk("rx_slrd_pulses", rd_cnt, 10);
      chk("rx_sloe_released", usb_sloe, 1);
      exp_b = '{4, 4, 2};
      chk("rx_burst_count", bursts.size(), exp_b.size());
      for (int i = 0; i < exp_b.size() && i < bursts.size(); i++) chk("rx_burst_len", bursts[i], exp_b[i]);

      // Flush: 5 words, flush with the last one
      pktend_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         w = DW'(16'hB000 + i); tx_src.push_back(w); tx_exp.push_back(w);
      end
      flush_on_last = 1;
      for (int i = 0; i < 300 && tx_exp.size() != 0; i++) @(negedge IFCLK);
      repeat (10) @(negedge IFCLK);
      chk("flush5_drained", tx_exp.size(), 0);
      chk("flush5_pktend_count", pktend_cnt, 1);
      chk("flush5_pktend_delay", last_pe_cyc - last_wr_cyc, 1);

      // Flush at word count 0 is dropped
      pktend_cnt = 0; flush_now = 1;
      repeat (30) @(negedge IFCLK);
      chk("flush0_pktend_count", pktend_cnt, 0);

      // TX backpressure: 300 words, full for 20 cycles after word 100
      wr_cnt = 0; fx2_words = 0; full_at = 100;
      for (int i = 0; i < 300; i++) begin
         w = DW'(i * 7 + 3); tx_src.push_back(w); tx_exp.push_back(w);
      end
      for (int i = 0; i < 5000 && tx_exp.size() != 0; i++) @(negedge IFCLK);
      chk("bp_drained", tx_exp.size(), 0);
      chk("bp_slwr_pulses", wr_cnt, 300);
      full_at = -1; pktend_cnt = 0; flush_now = 1;
      repeat (30) @(negedge IFCLK);
      chk("bp_flush_pktend", pktend_cnt, 1);

      // Exactly one packet: count wraps to 0, flush on that last word is dropped
      wr_cnt = 0; pktend_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         w = DW'(16'h5000 + i); tx_src.push_back(w); tx_exp.push_back(w);
      end
      flush_on_last = 1;
      for (int i = 0; i < 5000 && tx_exp.size() != 0; i++) @(negedge IFCLK);
      repeat (30) @(negedge IFCLK);
      chk("wrap_slwr_pulses", wr_cnt, 256);
      chk("wrap_pktend_count", pktend_cnt, 0);

      // Arbitration: both sides pending, bursts alternate starting with RX
      bursts.delete();
      for (int i = 0; i < 8; i++) begin
         w = DW'(16'hC000 + i); rx_model.push_back(w); rx_exp.push_back(w);
         w = DW'(16'hD000 + i); tx_src.push_back(w); tx_exp.push_back(w);
      end
      for (int i = 0; i < 500 && (tx_exp.size() != 0 || rx_exp.size() != 0); i++) @(negedge IFCLK);
      repeat (6) @(negedge IFCLK);
      exp_b = '{4, -4, 4, -4};
      chk("arb_burst_count", bursts.size(), exp_b.size());
      for (int i = 0; i < exp_b.size() && i < bursts.size(); i++) chk("arb_burst", bursts[i], exp_b[i]);

      // Reset in the middle of TX_WR
      for (int i = 0; i < 20; i++) begin
         w = DW'(16'hE000 + i); tx_src.push_back(w); tx_exp.push_back(w);
      end
      begin
         int k;
         for (k = 0; k < 200 && usb_slwr !== 1'b0; k++) @(negedge IFCLK);
         chk("rst_mid_reached_write", usb_slwr, 0);
      end
      @(posedge IFCLK); #3 rst_n = 1'b0;
      #1;
      chk("async_slwr", usb_slwr, 1);     chk("async_oe_n", usb_fd_oe_n, 1);
      chk("async_pktend", usb_pktend, 1); chk("async_fd_out", usb_fd_out, 0);
      repeat (3) @(negedge IFCLK);
      tx_src.delete(); tx_exp.delete(); bursts.delete();
      for (int i = 0; i < 2; i++) begin
         w = DW'(16'h1100 + i); rx_model.push_back(w); rx_exp.push_back(w);
         w = DW'(16'h2200 + i); tx_src.push_back(w); tx_exp.push_back(w);
      end
      @(posedge IFCLK); #2 rst_n = 1'b1;
      for (int i = 0; i < 300 && (tx_exp.size() != 0 || rx_exp.size() != 0); i++) @(negedge IFCLK);
      repeat (6) @(negedge IFCLK);
      chk("post_rst_burst_count", bursts.size(), 2);
      if (bursts.size() > 0) chk("post_rst_first_grant_rx", bursts[0], 2);

      // Idle short packet: 3 words then silence
      pktend_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         w = DW'(16'h3300 + i); tx_src.push_back(w); tx_exp.push_back(w);
      end
      for (int i = 0; i < 300 && tx_exp.size() != 0; i++) @(negedge IFCLK);
      repeat (40) @(negedge IFCLK);
`ifdef USB_TX_AUTO_PKTEND_EN
      chk("auto_pktend_count", pktend_cnt, 1);
      chk("auto_pktend_delay_ok", ((last_pe_cyc - last_wr_cyc) >= 16) && ((last_pe_cyc - last_wr_cyc) <= 24), 1);
`else
      chk("no_auto_pktend", pktend_cnt, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
